// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the UART command parser.
//   - command codes recognised after the escape byte
//   - parser FSM state encoding
//   - UART receiver FSM state encoding
package cmd_pkg;

  localparam logic [7:0] CMD_ESC  = 8'h00;
  localparam logic [7:0] CMD_RST  = 8'hFF;
  localparam logic [7:0] CMD_PAT0 = 8'h10;
  localparam logic [7:0] CMD_PAT1 = 8'h11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ARG  = 2'd2,
    DATA = 2'd3
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/cmd_uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   din   - raw serial line (idle high), synchronised internally
//   data  - received byte, stable while valid is high
//   valid - one-cycle strobe for a byte whose stop bit was high
// Parameter CLKS_PER_BIT: clk cycles per UART bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid
);
  import cmd_pkg::*;

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;

  // Synchroniser plus one extra flop so a true falling edge can be seen;
  // all three reset to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RX_IDLE;
      clkCnt_q <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clkCnt_q <= clkCnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      valid_q  <= valid_d;
    end
  end

  // Start is armed only by a high-to-low transition, so a low stop bit
  // left on the line does not immediately look like a new start bit.
  always_comb begin
    state_d  = state_q;
    clkCnt_d = clkCnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        clkCnt_d = '0;
        bitIdx_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (clkCnt_q == HALF) begin
          clkCnt_d = '0;
          state_d  = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (clkCnt_q == FULL) begin
          clkCnt_d = '0;
          shift_d  = {sync2_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = RX_STOP;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (clkCnt_q == FULL) begin
          clkCnt_d = '0;
          valid_d  = sync2_q;
          state_d  = RX_IDLE;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data  = shift_q;
  assign valid = valid_q;

endmodule

// File: rtl/cmd.sv
// cmd: UART byte-stream command parser.
// Frames: 0x00 escapes into command mode (0xFF reset pulse, 0x10/0x11 set a
// pattern register from the next byte); a nonzero first byte N announces N
// payload bytes that are forwarded on data_out/data_valid.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   din        - UART receive line
//   rst_out    - one-cycle pulse on the reset command
//   data_out   - payload byte, qualified by data_valid
//   data_valid - one-cycle payload strobe
//   pattern0/1 - registers written by commands 0x10/0x11
module cmd #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       rst_out,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [7:0] pattern0,
  output logic [7:0] pattern1
);
  import cmd_pkg::*;

  logic [7:0]   rxData;
  logic         rxValid;

  parse_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         code_q, code_d;
  logic [7:0]   pattern0_q, pattern0_d;
  logic [7:0]   pattern1_q, pattern1_d;
  logic         rstOut_q, rstOut_d;
  logic         dataValid_q, dataValid_d;
  logic [7:0]   dataOut_q, dataOut_d;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .data  (rxData),
    .valid (rxValid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= 1'b0;
      pattern0_q  <= '0;
      pattern1_q  <= '0;
      rstOut_q    <= 1'b0;
      dataValid_q <= 1'b0;
      dataOut_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      pattern0_q  <= pattern0_d;
      pattern1_q  <= pattern1_d;
      rstOut_q    <= rstOut_d;
      dataValid_q <= dataValid_d;
      dataOut_q   <= dataOut_d;
    end
  end

  // code_q only needs to tell the two pattern commands apart: 1 selects
  // pattern1. data_out keeps the last payload byte between strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    pattern0_d  = pattern0_q;
    pattern1_d  = pattern1_q;
    rstOut_d    = 1'b0;
    dataValid_d = 1'b0;
    dataOut_d   = dataOut_q;
    if (rxValid) begin
      case (state_q)
        IDLE: begin
          if (rxData == CMD_ESC) begin
            state_d = CMD;
          end else begin
            cnt_d   = rxData;
            state_d = DATA;
          end
        end
        CMD: begin
          state_d = IDLE;
          if (rxData == CMD_RST) begin
            rstOut_d = 1'b1;
          end else if (rxData == CMD_PAT0 || rxData == CMD_PAT1) begin
            code_d  = (rxData == CMD_PAT1);
            state_d = ARG;
          end
        end
        ARG: begin
          if (code_q) pattern1_d = rxData;
          else        pattern0_d = rxData;
          state_d = IDLE;
        end
        DATA: begin
          dataOut_d   = rxData;
          dataValid_d = 1'b1;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rst_out    = rstOut_q;
  assign data_out   = dataOut_q;
  assign data_valid = dataValid_q;
  assign pattern0   = pattern0_q;
  assign pattern1   = pattern1_q;

endmodule

// File: tb/tb_cmd.sv
// tb_cmd: directed testbench for the cmd UART command parser.
module tb_cmd;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       rst_out;
  logic [7:0] data_out;
  logic       data_valid;
  logic [7:0] pattern0;
  logic [7:0] pattern1;

  int errors = 0;
  int checks = 0;

  logic [7:0] dvQ[$];
  int         rstCount = 0;

  cmd #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .rst_out    (rst_out),
    .data_out   (data_out),
    .data_valid (data_valid),
    .pattern0   (pattern0),
    .pattern1   (pattern1)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Log every payload strobe and reset pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) dvQ.push_back(data_out);
      if (rst_out) rstCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    dvQ.delete();
    rstCount = 0;
  endtask

  // Send one 8N1 frame with a selectable stop-bit level, then idle two bits.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    @(negedge clk);
    din = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (CPB) @(negedge clk);
    end
    din = stopBit;
    repeat (CPB) @(negedge clk);
    din = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b1);
  endtask

  logic [7:0] seq35 [6] = '{8'h05, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'hF0};
  logic [7:0] exp35 [5] = '{8'hAA, 8'h55, 8'h00, 8'hFF, 8'hF0};

  initial begin
    rst = 1'b1;
    din = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_rst_out", {31'd0, rst_out}, 32'd0);
    checkOutput("reset_data_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("reset_data_out", {24'd0, data_out}, 32'd0);
    checkOutput("reset_pattern0", {24'd0, pattern0}, 32'd0);
    checkOutput("reset_pattern1", {24'd0, pattern1}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] reset command 00 FF");
    clearLog();
    sendByte(8'h00);
    sendByte(8'hFF);
    checkOutput("rstcmd_pulses", rstCount, 32'd1);
    checkOutput("rstcmd_no_data", dvQ.size(), 32'd0);
    checkOutput("rstcmd_pattern0", {24'd0, pattern0}, 32'd0);
    checkOutput("rstcmd_pattern1", {24'd0, pattern1}, 32'd0);

    $display("[TB] data frame 05 AA 55 00 FF F0");
    clearLog();
    foreach (seq35[i]) sendByte(seq35[i]);
    checkOutput("data_count", dvQ.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("data_byte%0d", i),
                  (i < dvQ.size()) ? {24'd0, dvQ[i]} : 32'hDEAD, {24'd0, exp35[i]});
    checkOutput("data_no_rst", rstCount, 32'd0);

    $display("[TB] pattern writes");
    clearLog();
    sendByte(8'h00); sendByte(8'h10); sendByte(8'hAA);
    checkOutput("pat0_write", {24'd0, pattern0}, 32'hAA);
    sendByte(8'h00); sendByte(8'h11); sendByte(8'h55);
    checkOutput("pat1_write", {24'd0, pattern1}, 32'h55);
    checkOutput("pat0_hold", {24'd0, pattern0}, 32'hAA);
    checkOutput("pat_no_data", dvQ.size(), 32'd0);

    $display("[TB] unknown command 00 42 then 00 FF");
    clearLog();
    sendByte(8'h00); sendByte(8'h42);
    checkOutput("unk_no_rst", rstCount, 32'd0);
    sendByte(8'h00); sendByte(8'hFF);
    checkOutput("unk_rst_pulses", rstCount, 32'd1);
    checkOutput("unk_no_data", dvQ.size(), 32'd0);
    checkOutput("unk_pattern0", {24'd0, pattern0}, 32'hAA);
    checkOutput("unk_pattern1", {24'd0, pattern1}, 32'h55);

    $display("[TB] glitch and bad stop bit");
    clearLog();
    @(negedge clk);
    din = 1'b0;
    repeat (5) @(negedge clk);
    din = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    applyStimulus(8'h00, 1'b0);
    // With the parser still idle, 01 77 is a one-byte payload frame.
    sendByte(8'h01); sendByte(8'h77);
    checkOutput("glitch_count", dvQ.size(), 32'd1);
    checkOutput("glitch_byte", (dvQ.size() > 0) ? {24'd0, dvQ[0]} : 32'hDEAD, 32'h77);
    checkOutput("glitch_no_rst", rstCount, 32'd0);

    $display("[TB] reset mid-frame");
    clearLog();
    sendByte(8'h02); sendByte(8'hAA);
    checkOutput("mid_first_payload", dvQ.size(), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("mid_reset_pattern0", {24'd0, pattern0}, 32'd0);
    checkOutput("mid_reset_pattern1", {24'd0, pattern1}, 32'd0);
    checkOutput("mid_reset_data_out", {24'd0, data_out}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clearLog();
    sendByte(8'h00); sendByte(8'h10); sendByte(8'h33);
    checkOutput("mid_pattern0", {24'd0, pattern0}, 32'h33);
    checkOutput("mid_no_data", dvQ.size(), 32'd0);
    checkOutput("mid_no_rst", rstCount, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd.md
CMD -- requirements
Module: cmd

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, is the number of clk cycles per UART bit (100 MHz clock, 115200 baud).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 din  input  1  UART receive line: idle high, 8N1, LSB first.
REQ-006 rst_out  output  1  one-cycle pulse when the reset command completes.
REQ-007 data_out  output  8  payload byte of a send-data frame.
REQ-008 data_valid  output  1  one-cycle strobe qualifying data_out.
REQ-009 pattern0  output  8  register written by command 0x10.
REQ-010 pattern1  output  8  register written by command 0x11.

Function
REQ-011 The receiver SHALL treat a falling edge on din as a start bit and confirm din low at mid-bit (CLKS_PER_BIT/2); a high sample there is a glitch and SHALL return the receiver to idle.
REQ-012 The receiver SHALL sample 8 data bits, LSB first, at the middle of each bit, then sample the stop bit.
REQ-013 A stop bit sampled low SHALL discard the byte with no strobe; a high stop bit SHALL raise an internal rx_valid for exactly one cycle.
REQ-014 The din input SHALL pass through a 2-flop synchronizer before use.
REQ-015 The parser FSM SHALL have the states IDLE, CMD, ARG and DATA, and SHALL act only on cycles where rx_valid is high.
REQ-016 In IDLE, byte 0x00 SHALL move the FSM to CMD.
REQ-017 In IDLE, a nonzero byte N SHALL load an 8-bit counter with N and move the FSM to DATA.
REQ-018 In DATA, each byte SHALL drive data_out = byte with data_valid high for one cycle, starting the cycle after rx_valid, and SHALL decrement the counter.
REQ-019 In DATA, the FSM SHALL return to IDLE after the Nth byte; any byte value, including 0x00, is payload.
REQ-020 In CMD, byte 0xFF SHALL pulse rst_out for one cycle (the cycle after rx_valid) and return the FSM to IDLE.
REQ-021 In CMD, byte 0x10 or 0x11 SHALL latch the code and move the FSM to ARG.
REQ-022 In CMD, any other byte SHALL be ignored, with the FSM returning to IDLE.
REQ-023 In ARG, the byte SHALL be written to pattern0 (code 0x10) or pattern1 (code 0x11), and the FSM SHALL return to IDLE.
REQ-024 The new pattern value SHALL be visible the cycle after rx_valid, and the pattern registers SHALL hold until rewritten or reset.
REQ-025 The block SHALL have no inter-byte timeout; partial frames wait indefinitely.
REQ-026 rst_out SHALL NOT reset the block itself or the pattern registers.

Reset
REQ-027 Reset SHALL set the FSM to IDLE, the receiver to idle and the counter to 0.
REQ-028 Reset SHALL set rst_out, data_valid, data_out, pattern0 and pattern1 to 0.
REQ-029 Reset asserted mid-byte or mid-frame SHALL abandon the partial byte or frame; reception restarts at the next start bit after reset deasserts.

Structure
REQ-030 A shared package SHALL hold the command codes: CMD_ESC = 0x00, CMD_RST = 0xFF, CMD_PAT0 = 0x10, CMD_PAT1 = 0x11.
REQ-031 The package SHALL also hold the FSM state encoding.
REQ-032 One sub-module, uart_rx, SHALL implement the receiver, with ports clk, rst, din, data[7:0], valid and parameter CLKS_PER_BIT.
REQ-033 The parser SHALL reside in cmd.

Verification
REQ-034 Bytes 00 FF -> exactly one rst_out pulse after the FF stop bit; patterns unchanged; data_valid never asserted.
REQ-035 Bytes 05 AA 55 00 FF F0 -> five data_valid strobes with data_out AA, 55, 00, FF, F0 in order; no rst_out (the embedded 00 FF is payload).
REQ-036 Bytes 00 10 AA -> pattern0 = 0xAA; 00 11 55 -> pattern1 = 0x55; pattern0 still 0xAA.
REQ-037 Bytes 00 42, then 00 FF -> 0x42 ignored; rst_out pulses once.
REQ-038 A 0.3-bit low glitch on din, or a frame with a low stop bit, -> no byte accepted; FSM state unchanged.
REQ-039 Reset asserted after 02 AA (one payload byte pending), then 00 10 33 -> pattern0 = 0x33; no data_valid after reset.
